// File: rtl/beta_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : beta_fetch_stage_pkg
//  Description : Shared types and constants for the beta instruction fetch
//                stage: the buffered fetch entry, the NOP used to replace
//                faulted instructions, and the default boot address.
//  Revision    : 1.0 - initial release
// ============================================================================
package beta_fetch_stage_pkg;

  // addi x0, x0, 0 -- substituted for the word of any faulted fetch
  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK         = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } fetch_entry_t;

endpackage : beta_fetch_stage_pkg
`default_nettype wire

// File: rtl/beta_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : beta_fetch_fifo
//  Description : Synchronous FIFO of fetch entries with a registered head.
//                Flush empties the buffer and overrides push and pop in the
//                same cycle. Pointers wrap modulo DEPTH (a power of two).
//  Ports       : clk_i, rst_i        - clock, async active-high reset
//                i_push, i_data      - write an entry
//                i_pop               - retire the head entry
//                i_flush             - discard all entries
//                o_count             - number of valid entries
//                o_head              - entry at the read pointer
//  Revision    : 1.0 - initial release
// ============================================================================
module beta_fetch_fifo
  import beta_fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         i_push,
  input  fetch_entry_t                 i_data,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output fetch_entry_t                 o_head
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam fetch_entry_t c_RESET_ENTRY = '{instr: NOP_INSTR, pc: 32'h0, err: 1'b0};

  fetch_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign w_pop  = i_pop  && !i_flush && (r_count != '0);
  assign w_push = i_push && !i_flush && (r_count != CW'(DEPTH));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      // Storage is reset so the head presents a NOP at pc 0 while empty.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= c_RESET_ENTRY;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule : beta_fetch_fifo
`default_nettype wire

// File: rtl/beta_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : beta_fetch_stage
//  Description : Instruction fetch stage. Owns the fetch PC, issues word
//                requests to instruction memory under a credit limit, buffers
//                responses tagged with their PC, and hands them to decode over
//                valid/ready. Redirects flush the buffer and discard any
//                responses still in flight.
//  Ports       : clk_i, rst_i                    - clock, async active-high reset
//                imem_req_o/addr_o/gnt_i          - request address phase
//                imem_rvalid_i/rdata_i/err_i      - in-order response phase
//                redirect_en_i/redirect_pc_i      - taken branch/jump from execute
//                dec_ready_i, if_valid_o,
//                if_instr_o/if_pc_o/if_err_o      - decode handshake and payload
//  Revision    : 1.0 - initial release
// ============================================================================
module beta_fetch_stage
  import beta_fetch_stage_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = DEFAULT_BOOT_ADDR,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_err_i,
  input  logic        redirect_en_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        dec_ready_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic        if_err_o
);

  localparam int          CW             = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] c_BOOT_ALIGNED = BOOT_ADDR & WORD_MASK;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] w_outstanding_next;
  logic [CW-1:0] w_fifo_count;
  logic [31:0]   w_redirect_pc;
  logic          w_credit;
  logic          w_grant;
  logic          w_resp;
  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

  // Buffered entries plus requests in flight (including ones to be discarded)
  // may never exceed the buffer size, so every response has a slot. A pop in
  // the same cycle deliberately does not release credit.
  assign w_credit = ({1'b0, w_fifo_count} + {1'b0, r_outstanding}) < (CW+1)'(FIFO_DEPTH);

  // Gated by reset so the request is quiet while reset is held.
  assign imem_req_o  = !rst_i && !redirect_en_i && w_credit;
  assign imem_addr_o = r_fetch_pc & WORD_MASK;

  assign w_grant            = imem_req_o && imem_gnt_i;
  // A response with nothing outstanding is a protocol violation; ignore it.
  assign w_resp             = imem_rvalid_i && (r_outstanding != '0);
  assign w_outstanding_next = r_outstanding + CW'(w_grant) - CW'(w_resp);
  assign w_redirect_pc      = redirect_pc_i & WORD_MASK;

  // A response landing in a redirect cycle belongs to the old path and is
  // dropped here; it is also excluded from the reloaded discard count.
  assign w_push = w_resp && (r_discard == '0) && !redirect_en_i;
  assign w_pop  = if_valid_o && dec_ready_i;

  assign w_push_entry = '{instr: (imem_err_i ? NOP_INSTR : imem_rdata_i),
                          pc:    r_resp_pc,
                          err:   imem_err_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_pc    <= c_BOOT_ALIGNED;
      r_resp_pc     <= c_BOOT_ALIGNED;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (redirect_en_i) begin
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_discard  <= w_outstanding_next;
      end else begin
        if (w_grant) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 32'd4;
        end
        if (w_resp && (r_discard != '0)) begin
          r_discard <= r_discard - CW'(1);
        end
      end
    end
  end

  beta_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_en_i),
    .o_count (w_fifo_count),
    .o_head  (w_head)
  );

  assign if_valid_o = (w_fifo_count != '0);
  assign if_instr_o = w_head.instr;
  assign if_pc_o    = w_head.pc;
  assign if_err_o   = w_head.err;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(imem_rvalid_i && (r_outstanding == '0)))
        else $error("beta_fetch_stage: imem_rvalid_i with no outstanding request");
    end
  end
`endif

endmodule : beta_fetch_stage
`default_nettype wire
